// File: rtl/gbe_cfg_pkg.sv
// Shared types and bit positions for the 10GbE reconfiguration sequencer.
package gbe_cfg_pkg;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_RUN       = 3'd1,
    ST_DRAIN     = 3'd2,
    ST_RESET     = 3'd3,
    ST_LOAD      = 3'd4,
    ST_WAIT_LINK = 3'd5
  } state_e;

  localparam int STAT_STATE_LSB = 0;
  localparam int STAT_STATE_W   = 3;
  localparam int STAT_LINK_TO   = 8;
  localparam int STAT_DRAIN_TO  = 9;
  localparam int STAT_LINK_UP   = 10;
  localparam int STAT_COUNT_LSB = 16;
  localparam int STAT_COUNT_W   = 16;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_RECONFIG = 1;

endpackage

// File: rtl/gbe_cfg_change_detect.sv
// Shadows the software config registers, waits for them to settle and raises a
// pending request that the sequencer clears once the new config is loaded.
module gbe_cfg_change_detect
  import gbe_cfg_pkg::*;
#(
  parameter int SETTLE_CYCLES = 64,
  parameter int CNT_W         = 21
) (
  input  logic        user_clk,
  input  logic        user_rst_n,
  input  logic [15:0] sw_port,
  input  logic [31:0] sw_ip,
  input  logic        sw_enable,
  input  logic        sw_reconfig,
  input  logic        pending_clr,
  output logic [15:0] shadow_port,
  output logic [31:0] shadow_ip,
  output logic        shadow_en,
  output logic        pending
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [15:0]      port_q, port_d;
  logic [31:0]      ip_q, ip_d;
  logic             en_q, en_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic             recfg_q, recfg_d;
  logic             pending_q, pending_d;
  logic             changed;
  logic             set_pending;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    port_d      = port_q;
    ip_d        = ip_q;
    en_d        = en_q;
    armed_d     = armed_q;
    settle_d    = settle_q;
    recfg_d     = sw_reconfig;
    set_pending = 1'b0;
    changed     = (sw_port != port_q) || (sw_ip != ip_q) || (sw_enable != en_q);

    if (changed) begin
      port_d   = sw_port;
      ip_d     = sw_ip;
      en_d     = sw_enable;
      armed_d  = 1'b1;
      settle_d = '0;
    end else if (armed_q) begin
      if (settle_q == SETTLE_LAST) begin
        set_pending = 1'b1;
        armed_d     = 1'b0;
        settle_d    = '0;
      end else begin
        settle_d = settle_q + CNT_W'(1);
      end
    end

    if (sw_reconfig && !recfg_q) set_pending = 1'b1;

    // A request arriving in the same cycle as the clear must survive it.
    pending_d = set_pending ? 1'b1 : (pending_clr ? 1'b0 : pending_q);
  end

  // NOTE: reset is synchronous (sampled on the edge) and state uses <= so every flop sees pre-edge values.
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      port_q    <= '0;
      ip_q      <= '0;
      en_q      <= 1'b0;
      armed_q   <= 1'b0;
      settle_q  <= '0;
      recfg_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      port_q    <= port_d;
      ip_q      <= ip_d;
      en_q      <= en_d;
      armed_q   <= armed_d;
      settle_q  <= settle_d;
      recfg_q   <= recfg_d;
      pending_q <= pending_d;
    end
  end

  assign shadow_port = port_q;
  assign shadow_ip   = ip_q;
  assign shadow_en   = en_q;
  assign pending     = pending_q;

endmodule

// File: rtl/gbe_cfg_sequencer.sv
// Sequences safe reconfiguration of the 10GbE TX core: drain at a packet
// boundary, pulse core reset, load port/IP, wait for link, re-enable transmit.
module gbe_cfg_sequencer
  import gbe_cfg_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int DRAIN_TIMEOUT = 4096,
  parameter int LINK_TIMEOUT  = 1048576,
  parameter int CNT_W         = 21
) (
  input  logic        user_clk,
  input  logic        user_rst_n,
  input  logic [31:0] sw_port,
  input  logic [31:0] sw_ip,
  input  logic [31:0] sw_ctrl,
  input  logic        pkt_boundary,
  input  logic        gbe_link_up,
  output logic        tx_gate,
  output logic        gbe_rst,
  output logic [15:0] gbe_port,
  output logic [31:0] gbe_ip,
  output logic [31:0] status
);

  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LINK_LAST  = CNT_W'(LINK_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_gate_q, tx_gate_d;
  logic             gbe_rst_q, gbe_rst_d;
  logic [15:0]      port_q, port_d;
  logic [31:0]      ip_q, ip_d;
  logic [15:0]      count_q, count_d;
  logic             link_to_q, link_to_d;
  logic             drain_to_q, drain_to_d;
  logic             link_up_q, link_up_d;
  logic             retry_q, retry_d;

  logic [15:0]      shadow_port;
  logic [31:0]      shadow_ip;
  logic             shadow_en;
  logic             pending;
  logic             pending_clr;
  logic             unused_sw_bits;

  assign unused_sw_bits = ^{sw_port[31:16], sw_ctrl[31:2]};

  gbe_cfg_change_detect #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_change_detect (
    .user_clk   (user_clk),
    .user_rst_n (user_rst_n),
    .sw_port    (sw_port[15:0]),
    .sw_ip      (sw_ip),
    .sw_enable  (sw_ctrl[CTRL_ENABLE]),
    .sw_reconfig(sw_ctrl[CTRL_RECONFIG]),
    .pending_clr(pending_clr),
    .shadow_port(shadow_port),
    .shadow_ip  (shadow_ip),
    .shadow_en  (shadow_en),
    .pending    (pending)
  );

  // Outputs decode the current state, so they settle one cycle after each transition.
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    tx_gate_d   = 1'b0;
    gbe_rst_d   = 1'b0;
    port_d      = port_q;
    ip_d        = ip_q;
    count_d     = count_q;
    link_to_d   = link_to_q;
    drain_to_d  = drain_to_q;
    link_up_d   = gbe_link_up;
    retry_d     = retry_q;
    pending_clr = 1'b0;

    unique case (state_q)
      ST_OFF: begin
        gbe_rst_d = 1'b1;
        retry_d   = 1'b0;
        if (shadow_en && pending) state_d = ST_RESET;
      end
      ST_RUN: begin
        tx_gate_d = 1'b1;
        if (pending || !shadow_en) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pkt_boundary || cnt_q == DRAIN_LAST) begin
          drain_to_d = drain_to_q | ~pkt_boundary;
          state_d    = shadow_en ? ST_RESET : ST_OFF;
        end else begin
          tx_gate_d = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      ST_RESET: begin
        gbe_rst_d = 1'b1;
        if (!shadow_en)             state_d = ST_OFF;
        else if (cnt_q == RST_LAST) state_d = ST_LOAD;
        else                        cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_LOAD: begin
        port_d      = shadow_port;
        ip_d        = shadow_ip;
        pending_clr = 1'b1;
        if (!retry_q) count_d = count_q + 16'd1;
        retry_d     = 1'b0;
        state_d     = ST_WAIT_LINK;
      end
      ST_WAIT_LINK: begin
        if (!shadow_en) begin
          state_d = ST_OFF;
        end else if (gbe_link_up) begin
          state_d    = ST_RUN;
          link_to_d  = 1'b0;
          drain_to_d = 1'b0;
        end else if (cnt_q == LINK_LAST) begin
          state_d   = ST_RESET;
          link_to_d = 1'b1;
          retry_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      state_q    <= ST_OFF;
      cnt_q      <= '0;
      tx_gate_q  <= 1'b0;
      gbe_rst_q  <= 1'b1;
      port_q     <= '0;
      ip_q       <= '0;
      count_q    <= '0;
      link_to_q  <= 1'b0;
      drain_to_q <= 1'b0;
      link_up_q  <= 1'b0;
      retry_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_gate_q  <= tx_gate_d;
      gbe_rst_q  <= gbe_rst_d;
      port_q     <= port_d;
      ip_q       <= ip_d;
      count_q    <= count_d;
      link_to_q  <= link_to_d;
      drain_to_q <= drain_to_d;
      link_up_q  <= link_up_d;
      retry_q    <= retry_d;
    end
  end

  always_comb begin
    status = '0;
    status[STAT_STATE_LSB +: STAT_STATE_W] = state_q;
    status[STAT_LINK_TO]                   = link_to_q;
    status[STAT_DRAIN_TO]                  = drain_to_q;
    status[STAT_LINK_UP]                   = link_up_q;
    status[STAT_COUNT_LSB +: STAT_COUNT_W] = count_q;
  end

  assign tx_gate  = tx_gate_q;
  assign gbe_rst  = gbe_rst_q;
  assign gbe_port = port_q;
  assign gbe_ip   = ip_q;

endmodule
